// File: rtl/st_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// st_pkg : shared declarations for the bit-serial adder slice.
//   st_state_e : controller states (IDLE, RUN)
//   ST_WIDTH   : default operand / sum width
// ---------------------------------------------------------------------------
package st_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } st_state_e;

  localparam int ST_WIDTH = 8;

endpackage : st_pkg

// File: rtl/st_serial_adder_if.sv
// ---------------------------------------------------------------------------
// st_serial_adder_if : request / result bundle of the serial adder.
//
// Handshake: the master raises start together with a, b, ci. The request is
// taken at a rising clk edge only while busy is low (state IDLE); a request
// seen while busy is high is dropped, not queued. Once accepted, busy stays
// high for WIDTH cycles, then done pulses for one cycle with sum / co updated.
//
//   start, a, b, ci : master -> slave
//   busy, done      : slave  -> master, status
//   sum, co         : slave  -> master, last completed result
//   state           : slave  -> master, controller state for observation
// ---------------------------------------------------------------------------
interface st_serial_adder_if
  import st_pkg::*;
#(
  parameter int WIDTH = ST_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  st_state_e        state;

  modport master (
    output start, a, b, ci,
    input  busy, done, sum, co, state
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, sum, co, state
  );

endinterface : st_serial_adder_if

// File: rtl/st_serial_adder_fa.sv
// ---------------------------------------------------------------------------
// st_fa : 1-bit combinational full adder from gate primitives.
//   x, y : operand bits
//   cin  : carry in
//   s    : sum bit   = x ^ y ^ cin
//   c    : carry out = (x & y) | (cin & (x ^ y))
// ---------------------------------------------------------------------------
module st_fa (
  output logic s,
  output logic c,
  input  logic x,
  input  logic y,
  input  logic cin
);

  logic w_p;   // propagate
  logic w_g;   // generate
  logic w_t;   // carry passed through on propagate

  xor g_p   (w_p, x, y);
  xor g_s   (s, w_p, cin);
  and g_g   (w_g, x, y);
  and g_t   (w_t, cin, w_p);
  or  g_c   (c, w_g, w_t);

endmodule : st_fa

// File: rtl/st_serial_adder.sv
// ---------------------------------------------------------------------------
// st_serial_adder : bit-serial unsigned adder, one bit per clock, LSB first.
//
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : st_serial_adder_if.slave (start/a/b/ci in, busy/done/sum/co/state out)
//
// An accepted start loads the operands into shift registers. Each RUN cycle
// the single full adder consumes bit 0 of both operand registers plus the
// carry flop; the sum bit enters the top of the partial register so that
// after WIDTH shifts it holds the result in natural bit order. sum / co only
// change on the final bit, so partial results never appear on the outputs.
// ---------------------------------------------------------------------------
module st_serial_adder
  import st_pkg::*;
#(
  parameter  int WIDTH = ST_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  st_serial_adder_if.slave    bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  st_state_e        r_state;
  st_state_e        w_state_nxt;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_co;
  logic             r_done;

  logic             w_s;
  logic             w_c;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_busy;

  // ---------------- full adder ----------------
  st_fa u_fa (
    .s   (w_s),
    .c   (w_c),
    .x   (r_sa[0]),
    .y   (r_sb[0]),
    .cin (r_carry)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (r_cnt == LAST_CNT) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / datapath controls ----------------
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = bus.start;
      end
      RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        w_last = (r_cnt == LAST_CNT);
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_sa    <= bus.a;
      r_sb    <= bus.b;
      r_part  <= '0;
      r_carry <= bus.ci;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
      r_part  <= {w_s, r_part[WIDTH-1:1]};
      r_carry <= w_c;
      // Wraps on the last bit when WIDTH is a power of two; reloaded on start.
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Result registers: written only on the final bit, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_co   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_sum <= {w_s, r_part[WIDTH-1:1]};
        r_co  <= w_c;
      end
    end
  end

  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.co    = r_co;
  assign bus.state = r_state;

endmodule : st_serial_adder

// File: doc/st_serial_adder.md
Name: st_serial_adder

Overview:
Bit-serial N-bit adder. It is the additive counterpart of the team's gate-level full subtractor.
- Loads two operands and a carry-in on a start request.
- Processes one bit per clock, LSB first, through a single gate-level 1-bit full adder and a carry flip-flop.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, e.g. accumulators in the arithmetic exercises alongside the subtractor blocks.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH): bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to begin an addition; sampled on rising clk.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- ci  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum and co are valid and newly updated.
- sum  output  WIDTH  result register, A+B+ci mod 2^WIDTH.
- co  output  1  final carry-out of the addition.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time): state=IDLE; busy=0, done=0, sum=0, co=0; internal shift registers, carry flop and counter cleared.
- States: IDLE, RUN.
- IDLE → RUN: at a clk edge with start=1.
  - Captures a and b into shift registers sa and sb.
  - carry ← ci; cnt ← 0; busy ← 1.
- RUN, each edge:
  - Full adder computes s=sa[0]^sb[0]^carry and c=(sa[0]&sb[0])|(carry&(sa[0]^sb[0])).
  - sa and sb shift right by 1.
  - s enters the MSB of the partial-result shift register.
  - carry ← c; cnt ← cnt+1.
- RUN → IDLE: at the edge where cnt==WIDTH-1 (the WIDTH-th bit is processed).
  - sum ← completed partial register including this bit; co ← c.
  - busy ← 0; done ← 1 for exactly one cycle.
- Latency: start accepted at edge k → busy high in cycles after edges k..k+WIDTH-1; done high in the cycle after edge k+WIDTH. Exactly WIDTH cycles, no bubbles.
- sum and co hold the previous result throughout RUN; partial results are never visible. They hold after completion until the next completion or reset.
- start while busy=1: ignored; no effect on the operation in progress or on the captured operands.
- start during the done cycle: accepted, because state is IDLE. The new operation begins, done drops next cycle, and sum/co keep the just-completed result until the new one finishes.
- a, b and ci are don't-care except on the accepting edge.
- Reset mid-operation: aborts immediately. No done pulse; sum=0, co=0.
- Arithmetic: unsigned. Overflow is reported only via co; no wrap flag. Signed interpretation is left to the user.

Decomposition:
- Shared package st_pkg holds:
  - state enum (IDLE, RUN);
  - default width constant ST_WIDTH=8.
- Sub-module st_fa: 1-bit combinational full adder built from gate primitives (xor/and/or).
  - Ports: s, c, x, y, cin.
  - Instantiated once; all sequencing stays in st_serial_adder.

Test Plan (WIDTH=8):
- Basic add: a=8'h35, b=8'h4A, ci=0, start pulse → busy for 8 cycles; done in cycle 9 with sum=8'h7F, co=0.
- Carry ripple through all bits: a=8'hFF, b=8'h01, ci=0 → sum=8'h00, co=1. Then a=8'hFF, b=8'hFF, ci=1 → sum=8'hFF, co=1.
- Start while busy: start a=8'h10, b=8'h20; at cycle 3 pulse start with a=8'hAA, b=8'h55 → ignored; result sum=8'h30, co=0; exactly one done.
- Back-to-back: start accepted on the done cycle of a=8'h01+b=8'h02 (sum 8'h03) with a=8'h80+b=8'h80 → sum stays 8'h03 for 8 cycles, then becomes 8'h00 with co=1.
- Reset mid-operation: start a=8'h0F, b=8'h0F; drop rst_n asynchronously (between clk edges) at cycle 4 → busy=0, sum=0, co=0 immediately; no done. After release, a=8'h0F+b=8'h0F gives 8'h1E.
- Random sweep: 1000 random a, b, ci against the reference model {co,sum}=a+b+ci. Check exactly WIDTH cycles start-to-done, and that sum is stable while busy.
